// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared constants, FSM state encoding and the hazard
// compare helper for the stall controller.
package stall_ctrl_pkg;

  localparam int unsigned MULT_CYCLES = 5;
  localparam int unsigned DIV_CYCLES  = 10;
  localparam int unsigned MD_CNT_W    = 4;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } md_state_e;

  typedef logic [4:0] reg_idx_t;

  // A read must wait when the producing stage will not have the value
  // ready by the time the consumer needs it. Register 0 never hazards,
  // which also covers wa == 0 meaning "no write".
  function automatic logic hazard(input reg_idx_t   src,
                                  input logic       use_src,
                                  input logic [1:0] tuse,
                                  input reg_idx_t   wa,
                                  input logic [1:0] tnew);
    return use_src && (src != '0) && (src == wa) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: pipeline-side signal bundle of the stall controller.
//   master: pipeline (drives D/E/M stage info, receives enables/status)
//   slave : stall_ctrl
// Optional STALL_CTRL_PERF_EN adds the 32-bit stall_cycles counter output.
interface stall_ctrl_if;
  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic       use_rs_D;
  logic       use_rt_D;
  logic [1:0] tuse_rs_D;
  logic [1:0] tuse_rt_D;
  logic [4:0] wa_E;
  logic [4:0] wa_M;
  logic [1:0] tnew_E;
  logic [1:0] tnew_M;
  logic       md_start_E;
  logic       md_is_div_E;
  logic       md_use_D;
  logic       en_PC;
  logic       en_D;
  logic       clr_E;
  logic       md_busy;
  logic [3:0] md_cnt;
`ifdef STALL_CTRL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  modport master (
    output rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D,
    output wa_E, wa_M, tnew_E, tnew_M, md_start_E, md_is_div_E, md_use_D,
    input  en_PC, en_D, clr_E, md_busy, md_cnt
`ifdef STALL_CTRL_PERF_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D,
    input  wa_E, wa_M, tnew_E, tnew_M, md_start_E, md_is_div_E, md_use_D,
    output en_PC, en_D, clr_E, md_busy, md_cnt
`ifdef STALL_CTRL_PERF_EN
    , output stall_cycles
`endif
  );
endinterface

// File: rtl/stall_ctrl_md_busy_timer.sv
// md_busy_timer: HI/LO unit occupancy FSM (IDLE/MULT/DIV) with a down
// counter of remaining busy cycles. Start requests while busy are ignored.
// Ports: clk, reset (sync, active-low), start, is_div -> busy, cnt.
module md_busy_timer
  import stall_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                is_div,
  output logic                busy,
  output logic [MD_CNT_W-1:0] cnt
);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = is_div ? MD_DIV : MD_MULT;
          cnt_d   = is_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
        end
      end
      MD_MULT, MD_DIV: begin
        if (cnt_q == MD_CNT_W'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q != MD_IDLE);
  assign cnt  = cnt_q;

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline hazard/stall controller. Freezes PC and D and
// bubbles E on register-read data hazards against E/M producers and on
// HI/LO access while the mult/div unit is busy or starting.
// Ports: clk, reset (sync, active-low), bus (stall_ctrl_if.slave).
// Optional STALL_CTRL_PERF_EN: bus.stall_cycles counts stalled cycles.
module stall_ctrl
  import stall_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  stall_ctrl_if.slave  bus
);

  logic                data_stall;
  logic                md_stall;
  logic                stall;
  logic                md_busy_q;
  logic [MD_CNT_W-1:0] md_cnt_q;

  md_busy_timer u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.md_start_E),
    .is_div (bus.md_is_div_E),
    .busy   (md_busy_q),
    .cnt    (md_cnt_q)
  );

  assign data_stall =
      hazard(bus.rs_D, bus.use_rs_D, bus.tuse_rs_D, bus.wa_E, bus.tnew_E) |
      hazard(bus.rs_D, bus.use_rs_D, bus.tuse_rs_D, bus.wa_M, bus.tnew_M) |
      hazard(bus.rt_D, bus.use_rt_D, bus.tuse_rt_D, bus.wa_E, bus.tnew_E) |
      hazard(bus.rt_D, bus.use_rt_D, bus.tuse_rt_D, bus.wa_M, bus.tnew_M);

  // A starting op in E occupies HI/LO from the next edge, so D must wait now.
  assign md_stall = bus.md_use_D & (md_busy_q | bus.md_start_E);

  // Outputs are held quiescent while reset is asserted, before the
  // registered state has had an edge to clear.
  assign stall       = reset & (data_stall | md_stall);
  assign bus.en_PC   = ~stall;
  assign bus.en_D    = ~stall;
  assign bus.clr_E   = stall;
  assign bus.md_busy = reset & md_busy_q;
  assign bus.md_cnt  = reset ? md_cnt_q : '0;

`ifdef STALL_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (!reset)
      stall_cycles_q <= '0;
    else if (stall)
      stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  assign bus.stall_cycles = stall_cycles_q;
`endif

endmodule
